// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_1r1w_init RAM family.
package sram_pkg;

   // Init sequencer states: INIT sweeps the array, READY accepts port traffic.
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } sram_init_e;

   // Widest row the merge helper handles; rows are zero-extended into this.
   localparam int unsigned MAX_W = 1024;

   typedef logic [MAX_W-1:0] wide_t;

   // Elaboration-time sanity: rows must split into whole mask bytes.
   function automatic bit width_ok(input int unsigned width, input int unsigned byte_w);
      return (byte_w != 0) && (width % byte_w == 0) && (width <= MAX_W);
   endfunction

   // Replace the bytes of old_row whose mask bit is set with the matching
   // bytes of new_row. Mask bit k covers bits [k*byte_w +: byte_w].
   function automatic wide_t byte_merge(input wide_t       old_row,
                                        input wide_t       new_row,
                                        input wide_t       mask,
                                        input int unsigned width,
                                        input int unsigned byte_w);
      wide_t byte_ones;
      wide_t bit_mask;
      byte_ones = (wide_t'(1) << byte_w) - wide_t'(1);
      bit_mask  = '0;
      for (int unsigned k = 0; k < width / byte_w; k++) begin
         if ((mask & (wide_t'(1) << k)) != '0) begin
            bit_mask = bit_mask | (byte_ones << (k * byte_w));
         end
      end
      return (old_row & ~bit_mask) | (new_row & bit_mask);
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Zero-init sequencer: walks a row counter over the whole array after reset
// or a clear request, then reports ready.
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          init_we,
   output logic [AW-1:0] init_addr,
   output logic          rdy
);

   localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

   sram_init_e    state, state_next;
   logic [AW-1:0] cnt, cnt_next;

   // State and row counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         // NOTE: registers take non-blocking updates so every flop samples pre-edge values.
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: sweep rows in INIT, leave on the last row, CLR restarts.
   always_comb begin
      // NOTE: defaults first so no path through this block leaves a latch.
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         INIT: begin
            if (clr) begin
               cnt_next = '0;
            end else if (cnt == LAST_ROW) begin
               state_next = READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         READY: begin
            if (clr) begin
               state_next = INIT;
               cnt_next   = '0;
            end
         end
      endcase
   end

   assign init_we   = (state == INIT);
   assign init_addr = cnt;
   assign rdy       = (state == READY);

endmodule

// File: rtl/sram_1r1w_init.sv
// Single-clock 1R1W SRAM model with byte-masked writes, hardware zero-init,
// selectable read-during-write forwarding and a read-valid strobe.
module sram_1r1w_init
   import sram_pkg::*;
#(
   parameter int unsigned      DEPTH    = 128,
   parameter int unsigned      WIDTH    = 96,
   parameter int unsigned      BYTE     = 8,
   parameter bit               FWD      = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   localparam int unsigned     NB       = WIDTH / BYTE,
   localparam int unsigned     AW       = $clog2(DEPTH)
) (
   input  logic             CE,
   input  logic             RSTB,
   input  logic             CLR,
   output logic             RDY,
   input  logic [AW-1:0]    A1,
   input  logic             CSB1,
   input  logic             OEB1,
   output logic [WIDTH-1:0] O1,
   output logic             V1,
   input  logic [AW-1:0]    A2,
   input  logic             CSB2,
   input  logic             WEB2,
   input  logic [NB-1:0]    WBM2,
   input  logic [WIDTH-1:0] I2
);

   if (!width_ok(WIDTH, BYTE)) begin : g_bad_width
      $error("sram_1r1w_init: WIDTH must be a non-zero multiple of BYTE and fit MAX_W");
   end

   // DEPTH need not be a power of two, so addresses are range-checked.
   localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

   logic             init_we;
   logic [AW-1:0]    init_addr;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             a1_ok, a2_ok;
   logic             rd_acc, wr_acc;
   logic [WIDTH-1:0] old_row, merged_row, rd_row;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;

   sram_init_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_seq (
      .clk       (CE),
      .rst_n     (RSTB),
      .clr       (CLR),
      .init_we   (init_we),
      .init_addr (init_addr),
      .rdy       (RDY)
   );

   // Port acceptance: only when ready, and CLR on the same edge wins.
   assign a1_ok  = ({1'b0, A1} < DEPTH_X);
   assign a2_ok  = ({1'b0, A2} < DEPTH_X);
   assign rd_acc = RDY & ~CLR & ~CSB1;
   assign wr_acc = RDY & ~CLR & ~CSB2 & ~WEB2 & a2_ok;

   // Byte-masked write is a read-modify-write of the addressed row.
   assign old_row    = mem[A2];
   assign merged_row = WIDTH'(byte_merge(wide_t'(old_row), wide_t'(I2), wide_t'(WBM2),
                                         WIDTH, BYTE));

   // Shared write port: the init sweep owns it while not ready.
   always_comb begin
      we    = init_we | wr_acc;
      waddr = A2;
      wdata = merged_row;
      if (init_we) begin
         waddr = init_addr;
         wdata = INIT_VAL;
      end
   end

   // Read data source: zeros out of range, merged row when forwarding a same-row write.
   always_comb begin
      rd_row = '0;
      if (a1_ok) begin
         if (FWD && wr_acc && (A1 == A2)) begin
            rd_row = merged_row;
         end else begin
            rd_row = mem[A1];
         end
      end
   end

   // Array write process.
   // NOTE: the array has no reset; contents are defined only by the init sweep.
   always_ff @(posedge CE) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read data and one-cycle valid strobe; O1 holds between reads.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         O1 <= '0;
         V1 <= 1'b0;
      end else begin
         V1 <= rd_acc;
         if (rd_acc) begin
            O1 <= OEB1 ? '0 : rd_row;
         end
      end
   end

endmodule

// File: tb/tb_sram_1r1w_init.sv
// Directed bench for sram_1r1w_init: a 128-row forwarding instance and a
// 100-row non-forwarding instance with a non-zero init value share stimulus.
module tb_sram_1r1w_init;

   localparam int          DEPTH_A = 128;
   localparam int          DEPTH_B = 100;
   localparam int          W       = 96;
   localparam int          NB      = 12;
   localparam int          AW      = 7;
   localparam logic [W-1:0] INIT_B = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
   localparam logic [W-1:0] ROW5   = {{11{8'hA5}}, 8'h3C};
   localparam logic [W-1:0] ONES   = {W{1'b1}};

   logic          CE = 1'b0;
   logic          RSTB, CLR, CSB1, OEB1, CSB2, WEB2;
   logic [AW-1:0] A1, A2;
   logic [NB-1:0] WBM2;
   logic [W-1:0]  I2;

   logic          rdy_a, v1_a, rdy_b, v1_b;
   logic [W-1:0]  o1_a, o1_b;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W-1:0]  exp_b [DEPTH_B];

   always #5 CE = ~CE;

   sram_1r1w_init #(
      .DEPTH (DEPTH_A), .WIDTH (W), .BYTE (8), .FWD (1'b1), .INIT_VAL ('0)
   ) u_dut_a (
      .CE (CE), .RSTB (RSTB), .CLR (CLR), .RDY (rdy_a),
      .A1 (A1), .CSB1 (CSB1), .OEB1 (OEB1), .O1 (o1_a), .V1 (v1_a),
      .A2 (A2), .CSB2 (CSB2), .WEB2 (WEB2), .WBM2 (WBM2), .I2 (I2)
   );

   sram_1r1w_init #(
      .DEPTH (DEPTH_B), .WIDTH (W), .BYTE (8), .FWD (1'b0), .INIT_VAL (INIT_B)
   ) u_dut_b (
      .CE (CE), .RSTB (RSTB), .CLR (CLR), .RDY (rdy_b),
      .A1 (A1), .CSB1 (CSB1), .OEB1 (OEB1), .O1 (o1_b), .V1 (v1_b),
      .A2 (A2), .CSB2 (CSB2), .WEB2 (WEB2), .WBM2 (WBM2), .I2 (I2)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CE);
      #1;
   endtask

   task automatic idle();
      CSB1 = 1'b1; OEB1 = 1'b0; CSB2 = 1'b1; WEB2 = 1'b1; CLR = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic oeb);
      A1 = a; OEB1 = oeb; CSB1 = 1'b0;
      cyc();
      CSB1 = 1'b1; OEB1 = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [W-1:0] d);
      A2 = a; WBM2 = m; I2 = d; CSB2 = 1'b0; WEB2 = 1'b0;
      cyc();
      CSB2 = 1'b1; WEB2 = 1'b1;
   endtask

   // Counts edges of an init sweep, checking RDY exactly at the boundaries.
   // Requests issued in the middle of the sweep must be ignored.
   task automatic sweep(input string tag, input logic [W-1:0] hold_a);
      for (int n = 1; n <= DEPTH_A; n++) begin
         if (n == 10) begin
            CSB1 = 1'b0; A1 = 7'd5; CSB2 = 1'b0; WEB2 = 1'b0; A2 = 7'd5;
            WBM2 = {NB{1'b1}}; I2 = ONES;
         end
         if (n == 90) idle();
         cyc();
         if (n == 50) begin
            check({tag, "_v1_ignored"}, W'(v1_a), W'(0));
            check({tag, "_o1_hold"}, o1_a, hold_a);
         end
         if (n == DEPTH_B - 1) check({tag, "_rdy_b_early"}, W'(rdy_b), W'(0));
         if (n == DEPTH_B)     check({tag, "_rdy_b_rise"},  W'(rdy_b), W'(1));
         if (n == DEPTH_A - 1) check({tag, "_rdy_a_early"}, W'(rdy_a), W'(0));
         if (n == DEPTH_A)     check({tag, "_rdy_a_rise"},  W'(rdy_a), W'(1));
      end
   endtask

   initial begin
      RSTB = 1'b0; idle(); A1 = '0; A2 = '0; WBM2 = '0; I2 = '0;
      for (int r = 0; r < DEPTH_B; r++) exp_b[r] = INIT_B;

      // Reset state.
      #12;
      check("rst_o1", o1_a, '0);
      check("rst_v1", W'(v1_a), W'(0));
      check("rst_rdy", W'(rdy_a), W'(0));

      // Release and initial sweep.
      @(negedge CE);
      RSTB = 1'b1;
      sweep("init", '0);

      // Init contents and V1 pulse shape.
      rd(7'd0, 1'b0);
      check("row0_o1", o1_a, '0);
      check("row0_v1", W'(v1_a), W'(1));
      rd(7'd64, 1'b0);
      check("row64_a", o1_a, '0);
      check("row64_b", o1_b, INIT_B);
      cyc();
      check("v1_drop", W'(v1_a), W'(0));
      check("o1_hold_b", o1_b, INIT_B);
      rd(7'd127, 1'b0);
      check("row127_a", o1_a, '0);
      check("row127_v1", W'(v1_a), W'(1));
      check("b_oor_127", o1_b, '0);
      check("b_oor_v1", W'(v1_b), W'(1));
      rd(7'd5, 1'b0);
      check("init_wr_ignored", o1_a, '0);

      // Byte-masked writes.
      wr(7'd5, {NB{1'b1}}, {12{8'hA5}});
      wr(7'd5, 12'h001, 96'h3C);
      exp_b[5] = ROW5;
      rd(7'd5, 1'b0);
      check("mask_a", o1_a, ROW5);
      check("mask_b", o1_b, ROW5);
      wr(7'd5, 12'h000, ONES);
      rd(7'd5, 1'b0);
      check("mask_zero", o1_a, ROW5);

      // Same-edge read and write to row 9.
      A1 = 7'd9; CSB1 = 1'b0; A2 = 7'd9; WBM2 = 12'h002; I2 = 96'hFF00;
      CSB2 = 1'b0; WEB2 = 1'b0;
      cyc();
      idle();
      check("rdw_fwd1", o1_a, 96'hFF00);
      check("rdw_fwd0", o1_b, INIT_B);
      exp_b[9] = 96'hDEAD_BEEF_0123_4567_89AB_FFEF;
      rd(7'd9, 1'b0);
      check("after_rdw_a", o1_a, 96'hFF00);
      check("after_rdw_b", o1_b, exp_b[9]);

      // Output enable off still pulses V1.
      rd(7'd5, 1'b1);
      check("oeb_o1", o1_a, '0);
      check("oeb_v1", W'(v1_a), W'(1));

      // Out-of-range read and write on the 100-row instance.
      rd(7'd120, 1'b0);
      check("oor_rd_o1", o1_b, '0);
      check("oor_rd_v1", W'(v1_b), W'(1));
      wr(7'd110, {NB{1'b1}}, ONES);
      rd(7'd110, 1'b0);
      check("row110_a", o1_a, ONES);
      for (int r = 0; r < DEPTH_B; r++) begin
         rd(AW'(r), 1'b0);
         check($sformatf("b_row%0d", r), o1_b, exp_b[r]);
      end

      // CLR in READY: full re-init, requests ignored meanwhile.
      rd(7'd5, 1'b0);
      check("pre_clr", o1_a, ROW5);
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
      check("clr_rdy", W'(rdy_a), W'(0));
      sweep("clr", ROW5);
      rd(7'd5, 1'b0);
      check("clr_row5_a", o1_a, '0);
      check("clr_row5_b", o1_b, INIT_B);
      rd(7'd9, 1'b0);
      check("clr_row9_a", o1_a, '0);
      check("clr_row9_b", o1_b, INIT_B);
      rd(7'd110, 1'b0);
      check("clr_row110", o1_a, '0);

      // RSTB pulsed mid-INIT with the counter at 40.
      wr(7'd110, {NB{1'b1}}, ONES);
      rd(7'd110, 1'b0);
      check("pre_rst", o1_a, ONES);
      CLR = 1'b1;
      cyc();
      CLR = 1'b0;
      for (int n = 0; n < 40; n++) cyc();
      RSTB = 1'b0;
      #1;
      check("midrst_o1", o1_a, '0);
      check("midrst_v1", W'(v1_a), W'(0));
      check("midrst_rdy", W'(rdy_a), W'(0));
      #1;
      RSTB = 1'b1;
      sweep("rst", '0);
      rd(7'd0, 1'b0);
      check("rst_row0_b", o1_b, INIT_B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_1r1w_init.md
# sram_1r1w_init

Parametrised single-clock 1R1W SRAM behavioural model, the successor to the fixed 128x96 two-clock generated RAMs. It generalises depth, width and byte-mask granularity. It adds three behaviours: a hardware zero-init sequencer after reset or on request, configurable read-during-write forwarding, and a read-valid strobe. It sits in the generated-RAM layer and is instantiated by caches and buffers in place of per-size generated macros.

## Interface
- DEPTH, 128, number of rows (any value ≥2, need not be a power of two)
- WIDTH, 96, row width in bits; must be a multiple of BYTE
- BYTE, 8, write-mask granularity in bits; NB = WIDTH/BYTE mask bits
- AW, $clog2(DEPTH), address width (derived, not overridden)
- FWD, 1, 1 = same-address read during write returns new data; 0 = returns old data
- INIT_VAL, 0, WIDTH-bit value written to every row by the init sequencer

Ports:
- CE  in  1  clock, all logic on posedge
- RSTB  in  1  reset, asynchronous, active-low
- CLR  in  1  single-cycle request to re-run the init sequence
- RDY  out  1  1 = init complete, ports accepted
- A1  in  AW  read address
- CSB1  in  1  read select, active-low
- OEB1  in  1  output enable, active-low, sampled with the read
- O1  out  WIDTH  registered read data
- V1  out  1  read-valid, one-cycle pulse per accepted read
- A2  in  AW  write address
- CSB2  in  1  write select, active-low
- WEB2  in  1  write enable, active-low
- WBM2  in  NB  byte write mask, bit k enables bits [k*BYTE +: BYTE]
- I2  in  WIDTH  write data

## Operation
- FSM states: INIT and READY. RSTB low forces INIT with row counter = 0.
- INIT: each posedge writes INIT_VAL to row[counter] and increments the counter. On the edge writing row DEPTH-1, the FSM moves to READY.
- In INIT, RDY = 0. All CSB1/CSB2 requests are ignored: no write, V1 stays 0, O1 holds.
- READY: RDY = 1. CLR = 1 at an edge returns to INIT with the counter at 0. CLR in INIT restarts the counter at 0.
- Read accepted when RDY & ~CSB1 at an edge. On that edge O1 loads the row, or all zeros when OEB1 = 1. V1 = 1 for the following cycle.
- Write accepted when RDY & ~CSB2 & ~WEB2. Only bytes with a WBM2 bit set are updated. WBM2 = 0 is a no-op.
- Read and write to the same address on the same edge:
  - FWD = 1: O1 returns the merged row, with new bytes where WBM2 is set and old bytes elsewhere.
  - FWD = 0: O1 returns the old row.
- A1 ≥ DEPTH: read returns zeros and V1 still pulses. A2 ≥ DEPTH: write is dropped.
- CLR and a port request on the same edge: CLR wins and the request is dropped.
- RSTB does not clear the array. Contents are defined only after the init sequence completes.

## Timing
- Reset values: O1 = 0, V1 = 0, RDY = 0, FSM = INIT, counter = 0.
- RDY rises DEPTH edges after RSTB deassertion. The first edge after release writes row 0.
- Read latency is 1 cycle: request at edge n, O1/V1 valid after edge n, sampled at edge n+1.
- O1 holds its value when no read is accepted. V1 returns to 0.
- A write at edge n is visible to a read at edge n+1 with either FWD setting.
- Back-to-back reads and writes are sustained at 1 per cycle each. There are no stalls in READY.
- RSTB asserted mid-INIT or mid-read: immediate async clear of all outputs, then a full DEPTH-cycle init after release.

## Structure
- Shared package sram_pkg:
  - state enum sram_init_e {INIT, READY}
  - function byte_merge(old, new, mask) parametrised by WIDTH/BYTE
  - elaboration check that WIDTH % BYTE == 0
- One sub-module sram_init_seq: the FSM plus row counter. It outputs init_we, init_addr and rdy, which are muxed ahead of the write port in the top.
- The array is a plain reg array of WIDTH x DEPTH with a single write process, so the init mux and the user write share one port.

## Test plan
- Reset release with DEPTH=128: RDY rises exactly 128 cycles later. Reads of rows 0, 64 and 127 return INIT_VAL with V1 pulsing once each.
- Write row 5 with I2=all 0xA5, WBM2=all ones, then WBM2=0x001 with I2 byte0=0x3C: read row 5 returns 0xA5…A53C.
- Same-edge read and write at row 9 (old 0, new 0xFF in byte 1): FWD=1 returns 0xFF00, FWD=0 returns 0.
- CLR in READY after writes: RDY drops for DEPTH cycles. Requests in that window are ignored, and all rows read INIT_VAL afterwards.
- DEPTH=100, A1=120: O1=0 with V1=1. A write to A2=110 leaves all rows unchanged.
- RSTB pulsed low mid-INIT at counter=40: O1, V1 and RDY are 0 immediately, and RDY rises DEPTH cycles after release.
